// File: rtl/bldc_commutator_pkg.sv
// Shared definitions for the BLDC commutator and the downstream phase drivers:
// duty width, FSM state encoding, fault codes and the six-step commutation table.
package bldc_commutator_pkg;

   localparam int DUTY_CYCLE_WIDTH = 10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DEAD  = 3'd2,
      ST_BRAKE = 3'd3,
      ST_FAULT = 3'd4
   } state_t;

   localparam logic [1:0] FC_NONE  = 2'b00;
   localparam logic [1:0] FC_HALL  = 2'b01;
   localparam logic [1:0] FC_STALL = 2'b10;

   localparam logic [1:0] PH_A    = 2'd0;
   localparam logic [1:0] PH_B    = 2'd1;
   localparam logic [1:0] PH_C    = 2'd2;
   localparam logic [1:0] PH_NONE = 2'd3;

   function automatic logic hall_valid(input logic [2:0] code);
      return (code != 3'b000) && (code != 3'b111);
   endfunction

   // Forward drive: returns {high phase, low phase}; the remaining phase floats.
   function automatic logic [3:0] comm_fwd(input logic [2:0] code);
      logic [3:0] hl;
      case (code)
         3'b101:  hl = {PH_A, PH_B};
         3'b100:  hl = {PH_A, PH_C};
         3'b110:  hl = {PH_B, PH_C};
         3'b010:  hl = {PH_B, PH_A};
         3'b011:  hl = {PH_C, PH_A};
         3'b001:  hl = {PH_C, PH_B};
         default: hl = {PH_NONE, PH_NONE};
      endcase
      return hl;
   endfunction

endpackage

// File: rtl/bldc_commutator_hall_filter.sv
// Hall input synchroniser and stability filter; emits a one-cycle tick when the
// filtered code moves between two valid hall codes.
module bldc_commutator_hall_filter
   import bldc_commutator_pkg::*;
#(
   parameter int unsigned HALL_FILTER = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [2:0] hall,
   output logic [2:0] hall_filt,
   output logic       hall_tick
);

   localparam logic [7:0] FILT_LIM = 8'(HALL_FILTER);

   logic [2:0] sync1_r;
   logic [2:0] sync2_r;
   logic [2:0] prev_r;
   logic [2:0] filt_r;
   logic [7:0] cnt_r;
   logic [7:0] cnt_next_s;
   logic       accept_s;
   logic       tick_r;

   // Count consecutive cycles the synchronised code has held; saturate at the limit.
   always_comb begin
      cnt_next_s = cnt_r;
      accept_s   = 1'b0;
      if (sync2_r != prev_r) begin
         cnt_next_s = 8'd1;
      end else if (cnt_r != FILT_LIM) begin
         cnt_next_s = cnt_r + 8'd1;
      end else begin
         cnt_next_s = cnt_r;
      end
      if (cnt_next_s == FILT_LIM) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Synchroniser, stability counter, filtered code and transition tick.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= 3'b000;
         sync2_r <= 3'b000;
         prev_r  <= 3'b000;
         filt_r  <= 3'b000;
         cnt_r   <= 8'd0;
         tick_r  <= 1'b0;
      end else begin
         sync1_r <= hall;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
         cnt_r   <= cnt_next_s;
         if (accept_s) begin
            filt_r <= sync2_r;
         end else begin
            filt_r <= filt_r;
         end
         tick_r <= accept_s && (sync2_r != filt_r) && hall_valid(sync2_r) && hall_valid(filt_r);
      end
   end

   assign hall_filt = filt_r;
   assign hall_tick = tick_r;

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation stage: filtered hall plus duty/direction to per-phase
// duty and float requests, with reversal dead time, braking and latched faults.
module bldc_commutator
   import bldc_commutator_pkg::*;
#(
   parameter int          DUTY_W       = DUTY_CYCLE_WIDTH,
   parameter int unsigned HALL_FILTER  = 8,
   parameter int unsigned DEAD_CYCLES  = 64,
   parameter int unsigned STALL_CYCLES = 2_000_000
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              direction,
   input  logic              brake,
   input  logic [DUTY_W-1:0] duty_in,
   input  logic [2:0]        hall,
   output logic [DUTY_W-1:0] duty_a,
   output logic [DUTY_W-1:0] duty_b,
   output logic [DUTY_W-1:0] duty_c,
   output logic              high_z_a,
   output logic              high_z_b,
   output logic              high_z_c,
   output logic              fault,
   output logic [1:0]        fault_code,
   output logic [15:0]       hall_ticks
);

   localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYCLES - 1);
   localparam logic [23:0] STALL_LIM = 24'(STALL_CYCLES);

   state_t            state_r;
   state_t            state_next_s;
   logic              dir_r;
   logic              dir_next_s;
   logic              dir_prev_r;
   logic [15:0]       dead_cnt_r;
   logic [15:0]       dead_cnt_next_s;
   logic [1:0]        fault_code_r;
   logic [1:0]        fault_code_next_s;
   logic [23:0]       stall_cnt_r;
   logic              stall_s;
   logic [15:0]       ticks_r;
   logic [2:0]        hall_filt_s;
   logic              hall_tick_s;
   logic [3:0]        hi_lo_s;
   logic [1:0]        hi_s;
   logic [1:0]        lo_s;
   logic [DUTY_W-1:0] duty_s [3];
   logic [2:0]        hz_s;

   bldc_commutator_hall_filter #(
      .HALL_FILTER(HALL_FILTER)
   ) u_hall_filter (
      .clock    (clock),
      .reset_n  (reset_n),
      .hall     (hall),
      .hall_filt(hall_filt_s),
      .hall_tick(hall_tick_s)
   );

   assign stall_s = (stall_cnt_r >= STALL_LIM);

   // Next-state logic; direction is only adopted in IDLE or at the end of dead time.
   always_comb begin
      state_next_s      = state_r;
      dir_next_s        = dir_r;
      dead_cnt_next_s   = dead_cnt_r;
      fault_code_next_s = fault_code_r;
      case (state_r)
         ST_IDLE: begin
            dir_next_s = direction;
            if (enable && brake) begin
               state_next_s = ST_BRAKE;
            end else if (enable && hall_valid(hall_filt_s)) begin
               state_next_s = ST_RUN;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_next_s = ST_IDLE;
            end else if (!hall_valid(hall_filt_s)) begin
               state_next_s      = ST_FAULT;
               fault_code_next_s = FC_HALL;
            end else if (stall_s) begin
               state_next_s      = ST_FAULT;
               fault_code_next_s = FC_STALL;
            end else if (brake) begin
               state_next_s = ST_BRAKE;
            end else if (direction != dir_r) begin
               state_next_s    = ST_DEAD;
               dead_cnt_next_s = 16'd0;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_DEAD: begin
            if (!enable) begin
               state_next_s = ST_IDLE;
            end else if (direction != dir_prev_r) begin
               dead_cnt_next_s = 16'd0;
            end else if (dead_cnt_r == DEAD_LAST) begin
               dir_next_s   = direction;
               state_next_s = brake ? ST_BRAKE : ST_RUN;
            end else begin
               dead_cnt_next_s = dead_cnt_r + 16'd1;
            end
         end
         ST_BRAKE: begin
            if (!enable) begin
               state_next_s = ST_IDLE;
            end else if (brake) begin
               state_next_s = ST_BRAKE;
            end else if (direction != dir_r) begin
               state_next_s    = ST_DEAD;
               dead_cnt_next_s = 16'd0;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_FAULT: begin
            if (!enable) begin
               state_next_s      = ST_IDLE;
               fault_code_next_s = FC_NONE;
            end else begin
               state_next_s = ST_FAULT;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Per-phase drive computed from the next state so outputs land one cycle after the cause.
   always_comb begin
      hi_lo_s = comm_fwd(hall_filt_s);
      if (dir_next_s) begin
         hi_s = hi_lo_s[1:0];
         lo_s = hi_lo_s[3:2];
      end else begin
         hi_s = hi_lo_s[3:2];
         lo_s = hi_lo_s[1:0];
      end
      hz_s = 3'b111;
      for (int p = 0; p < 3; p++) begin
         duty_s[p] = {DUTY_W{1'b0}};
         case (state_next_s)
            ST_RUN: begin
               duty_s[p] = (hi_s == 2'(p)) ? duty_in : {DUTY_W{1'b0}};
               hz_s[p]   = !((hi_s == 2'(p)) || (lo_s == 2'(p)));
            end
            ST_BRAKE: hz_s[p] = 1'b0;
            default:  hz_s[p] = 1'b1;
         endcase
      end
   end

   // FSM state, direction, dead-time and fault-code registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= ST_IDLE;
         dir_r        <= 1'b0;
         dir_prev_r   <= 1'b0;
         dead_cnt_r   <= 16'd0;
         fault_code_r <= FC_NONE;
      end else begin
         state_r      <= state_next_s;
         dir_r        <= dir_next_s;
         dir_prev_r   <= direction;
         dead_cnt_r   <= dead_cnt_next_s;
         fault_code_r <= fault_code_next_s;
      end
   end

   // Stall counter and hall transition count.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_r <= 24'd0;
         ticks_r     <= 16'd0;
      end else begin
         if ((state_r == ST_RUN) && (duty_in != {DUTY_W{1'b0}}) && !hall_tick_s) begin
            stall_cnt_r <= stall_cnt_r + 24'd1;
         end else begin
            stall_cnt_r <= 24'd0;
         end
         if (hall_tick_s) begin
            ticks_r <= ticks_r + 16'd1;
         end else begin
            ticks_r <= ticks_r;
         end
      end
   end

   // Registered phase-driver outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         duty_a   <= {DUTY_W{1'b0}};
         duty_b   <= {DUTY_W{1'b0}};
         duty_c   <= {DUTY_W{1'b0}};
         high_z_a <= 1'b1;
         high_z_b <= 1'b1;
         high_z_c <= 1'b1;
         fault    <= 1'b0;
      end else begin
         duty_a   <= duty_s[0];
         duty_b   <= duty_s[1];
         duty_c   <= duty_s[2];
         high_z_a <= hz_s[0];
         high_z_b <= hz_s[1];
         high_z_c <= hz_s[2];
         fault    <= (state_next_s == ST_FAULT);
      end
   end

   assign fault_code = fault_code_r;
   assign hall_ticks = ticks_r;

endmodule

// File: doc/bldc_commutator.md
Name: bldc_commutator

Overview:
- Six-step BLDC commutation stage that sits directly upstream of the three per-phase PWM drivers.
- Synchronises and filters the 3-bit hall sensor input, then maps it with the commanded duty and direction to a per-phase duty_cycle and high_z.
- Adds direction-reversal dead time, braking, and latched fault detection for invalid hall codes and stall.
- Outputs feed the A/B/C phase drivers directly.

Parameters:
- DUTY_W, 10, duty width; equals the shared DUTY_CYCLE_WIDTH constant.
- HALL_FILTER, 8, consecutive stable cycles before a synchronised hall code is accepted (1..255).
- DEAD_CYCLES, 64, all-phase high-Z cycles inserted on a direction change (1..65535).
- STALL_CYCLES, 2_000_000, cycles without an accepted hall transition before a stall fault; 24-bit counter.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  motor enable; low forces IDLE and clears faults
- direction  in  1  0 = forward, 1 = reverse
- brake  in  1  low-side brake request
- duty_in  in  DUTY_W  commanded duty
- hall  in  3  raw hall sensors {H3,H2,H1}, asynchronous
- duty_a / duty_b / duty_c  out  DUTY_W  per-phase duty to the phase drivers
- high_z_a / high_z_b / high_z_c  out  1  per-phase float request
- fault  out  1  latched fault flag
- fault_code  out  2  00 none, 01 invalid hall, 10 stall
- hall_ticks  out  16  count of accepted valid hall transitions; wraps at 0xFFFF -> 0

Behaviour:
- Reset values: all duty outputs 0, all high_z 1, fault 0, fault_code 00, hall_ticks 0, state IDLE, filtered hall 000.
- Hall synchronisation and filtering:
  - Two-flop synchroniser on hall.
  - Filter counter restarts whenever the synchronised code differs from the previous cycle.
  - The filtered code updates when the synchronised code has been equal for HALL_FILTER consecutive cycles.
- Latency: all outputs are registered and reflect state and filtered hall one cycle later. Raw hall edge to output change = 2 + HALL_FILTER + 1 cycles.
- Forward commutation table (filtered hall -> high phase / low phase / floating phase):
  - 101 -> A / B / C
  - 100 -> A / C / B
  - 110 -> B / C / A
  - 010 -> B / A / C
  - 011 -> C / A / B
  - 001 -> C / B / A
  - Reverse direction swaps the high and low phases.
- Drive encoding:
  - High phase: duty = duty_in, high_z = 0.
  - Low phase: duty = 0, high_z = 0.
  - Floating phase: duty = 0, high_z = 1.
- State machine:
  - IDLE: all high_z = 1, duty 0. Goes to RUN when enable=1, brake=0 and the filtered hall is valid. Goes to BRAKE when enable=1 and brake=1.
  - RUN: table drive. Transitions, in priority order:
    - FAULT on filtered hall 000 or 111.
    - FAULT on stall.
    - BRAKE when brake=1.
    - DEAD when the registered direction differs from the direction input.
  - DEAD: all high_z = 1 for exactly DEAD_CYCLES cycles. Then latches the new direction and returns to RUN, or to BRAKE if brake=1. A further direction toggle during DEAD restarts the count.
  - BRAKE: all high_z = 0, duty 0 (low sides on). Returns to RUN when brake=0, passing through DEAD first if direction changed.
  - FAULT: all high_z = 1, duty 0, fault = 1, fault_code held. Exits only to IDLE when enable=0; fault and fault_code clear on that transition.
- enable=0 in any state: next state IDLE, except FAULT, which also goes to IDLE but clears the fault.
- Stall counter:
  - Counts only in RUN with duty_in != 0.
  - Clears on every accepted valid hall transition, on leaving RUN, and whenever duty_in = 0.
  - Reaching STALL_CYCLES raises the stall fault.
- hall_ticks: increments on each change of the filtered code between two valid codes in any state. Does not reset on fault; reset_n only.
- Simultaneous events in RUN: invalid hall beats stall, stall beats brake, brake beats direction change.
- duty_in is sampled every cycle in RUN; no extra holding.
- reset_n asserted mid-operation: outputs go immediately (asynchronously) to reset values.

Decomposition:
- Shared header with the phase drivers: DUTY_CYCLE_WIDTH, state encodings, fault_code constants.
- One natural sub-module: hall_filter (synchroniser, stability counter, filtered code, valid-transition pulse).
- Commutation table and FSM stay in bldc_commutator.

Test Plan:
1. Reset release with enable=1, hall=101, duty_in=300, direction=0 -> after 2+8+1 cycles: duty_a=300, high_z_a=0; duty_b=0, high_z_b=0; high_z_c=1.
2. Step hall 101->100->110->010->011->001 with 20 cycles per step -> phases follow the forward table, hall_ticks=5. Repeat with direction=1 -> high and low phases swapped after a 64-cycle all-high-Z DEAD window.
3. Hall glitch of 5 cycles (101->100->101) -> filtered code and outputs unchanged, hall_ticks unchanged.
4. Hall forced to 111 for 20 cycles in RUN -> fault=1, fault_code=01, all high_z=1. Pulse enable low for 1 cycle -> fault clears, state IDLE.
5. RUN with duty_in=100 and hall static, STALL_CYCLES overridden to 1000 -> fault_code=10 at cycle 1000. Same scenario with duty_in=0 -> no fault.
6. brake=1 and direction toggle in the same RUN cycle -> BRAKE (all high_z=0, duty 0). Release brake -> DEAD for 64 cycles -> RUN in the reverse direction.
